// File: rtl/syncqual_if.sv
// Measurement/result bundle for the multi-channel sync-position qualifier.
// Channel c occupies bits [c*NBITS +: NBITS] of i_val and o_val.
interface syncqual_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned NBITS = 16
);
    logic                 i_clear;
    logic [NCH-1:0]       i_v;
    logic [NCH*NBITS-1:0] i_val;
    logic [NCH*NBITS-1:0] o_val;
    logic [NCH-1:0]       o_locked;
    logic [NCH-1:0]       o_lost;
    logic                 o_all_locked;

    modport master (
        output i_clear, i_v, i_val,
        input  o_val, o_locked, o_lost, o_all_locked
    );

    modport slave (
        input  i_clear, i_v, i_val,
        output o_val, o_locked, o_lost, o_all_locked
    );
endinterface

// File: rtl/syncqual.sv
// Per-channel sync-position qualifier: credibility counter with lock hysteresis.
// Optional macro SYNCQUAL_HOLD_EN keeps the last locked position on o_val after unlock.
module syncqual #(
    parameter int unsigned NCH          = 2,
    parameter int unsigned NBITS        = 16,
    parameter int unsigned QUALITY_BITS = 3,
    parameter int unsigned UNLOCK_LEVEL = 3,
    parameter int unsigned TOLERANCE    = 0
) (
    input logic       i_clk,
    input logic       i_reset_n,
    syncqual_if.slave bus
);
    localparam int unsigned DW = NBITS + 1;
    localparam logic [QUALITY_BITS-1:0] LMAX = '1;
    localparam logic [QUALITY_BITS-1:0] ULVL = QUALITY_BITS'(UNLOCK_LEVEL);
    localparam logic [DW-1:0]           TOL  = DW'(TOLERANCE);

    logic [NCH-1:0]          sv_q, sv_d, smatch_q, smatch_d;
    logic [NBITS-1:0]        sval_q [NCH];
    logic [NBITS-1:0]        sval_d [NCH];
    logic [NBITS-1:0]        ref_q  [NCH];
    logic [NBITS-1:0]        ref_d  [NCH];
    logic [QUALITY_BITS-1:0] ngood_q [NCH];
    logic [QUALITY_BITS-1:0] ngood_d [NCH];
    logic [NCH-1:0]          locked_q, locked_d, lost_q, lost_d;
    logic                    all_q, all_d;
    logic [NCH*NBITS-1:0]    val_q, val_d;

    // Non-wrapping absolute difference on NBITS+1 bits.
    function automatic logic [DW-1:0] abs_diff(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        logic [DW-1:0] ea, eb;
        ea = DW'(a);
        eb = DW'(b);
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    always_comb begin
        sv_d     = '0;
        smatch_d = '0;
        locked_d = locked_q;
        lost_d   = '0;
        val_d    = val_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            sval_d[c]  = '0;
            ref_d[c]   = ref_q[c];
            ngood_d[c] = ngood_q[c];

            // Stage B: capture a new candidate or move the credibility counter.
            if (sv_q[c]) begin
                if (ngood_q[c] == '0) begin
                    ref_d[c]   = sval_q[c];
                    ngood_d[c] = QUALITY_BITS'(1);
                end else if (smatch_q[c]) begin
                    if (ngood_q[c] != LMAX) ngood_d[c] = ngood_q[c] + 1'b1;
                end else begin
                    ngood_d[c] = ngood_q[c] - 1'b1;
                end
            end

            // Stage A: match against the reference the sample will actually meet in stage B.
            sv_d[c]     = bus.i_v[c];
            sval_d[c]   = bus.i_val[c*NBITS +: NBITS];
            smatch_d[c] = (abs_diff(sval_d[c], ref_d[c]) <= TOL);

            // Stage C: lock state from the settled counter.
            if (ngood_q[c] == LMAX) begin
                locked_d[c] = 1'b1;
            end else if (locked_q[c] && (ngood_q[c] <= ULVL)) begin
                locked_d[c] = 1'b0;
                lost_d[c]   = 1'b1;
            end

            if (locked_d[c]) begin
                val_d[c*NBITS +: NBITS] = ref_q[c];
            end else begin
`ifdef SYNCQUAL_HOLD_EN
                val_d[c*NBITS +: NBITS] = val_q[c*NBITS +: NBITS];
`else
                val_d[c*NBITS +: NBITS] = '0;
`endif
            end
        end

        if (bus.i_clear) begin
            sv_d     = '0;
            smatch_d = '0;
            locked_d = '0;
            lost_d   = '0;
            val_d    = '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                sval_d[c]  = '0;
                ref_d[c]   = '0;
                ngood_d[c] = '0;
            end
        end

        all_d = &locked_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sv_q     <= '0;
            smatch_q <= '0;
            locked_q <= '0;
            lost_q   <= '0;
            all_q    <= 1'b0;
            val_q    <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                sval_q[c]  <= '0;
                ref_q[c]   <= '0;
                ngood_q[c] <= '0;
            end
        end else begin
            sv_q     <= sv_d;
            smatch_q <= smatch_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            all_q    <= all_d;
            val_q    <= val_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                sval_q[c]  <= sval_d[c];
                ref_q[c]   <= ref_d[c];
                ngood_q[c] <= ngood_d[c];
            end
        end
    end

    assign bus.o_val        = val_q;
    assign bus.o_locked     = locked_q;
    assign bus.o_lost       = lost_q;
    assign bus.o_all_locked = all_q;
endmodule

// File: tb/tb_syncqual.sv
// Directed bench for syncqual: dut_a uses TOLERANCE=0, dut_b TOLERANCE=2, both fed identical stimulus.
// Expectations follow the build's SYNCQUAL_HOLD_EN setting.
module tb_syncqual;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef SYNCQUAL_HOLD_EN
    localparam logic [15:0] UNLOCK_VAL = 16'd100;
`else
    localparam logic [15:0] UNLOCK_VAL = 16'd0;
`endif

    syncqual_if #(.NCH(2), .NBITS(16)) ifa ();
    syncqual_if #(.NCH(2), .NBITS(16)) ifb ();

    syncqual #(.NCH(2), .NBITS(16), .QUALITY_BITS(3), .UNLOCK_LEVEL(3), .TOLERANCE(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifa)
    );
    syncqual #(.NCH(2), .NBITS(16), .QUALITY_BITS(3), .UNLOCK_LEVEL(3), .TOLERANCE(2)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [1:0] v, input logic [15:0] a, input logic [15:0] b);
        ifa.i_v = v;  ifa.i_val = {b, a};
        ifb.i_v = v;  ifb.i_val = {b, a};
    endtask

    // One sample per call; returns just after the edge that captured it.
    task automatic send(input logic [1:0] v, input logic [15:0] a, input logic [15:0] b);
        set_in(v, a, b);
        @(negedge clk);
        set_in(2'b00, 16'd0, 16'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        ifa.i_clear = 1'b1;  ifb.i_clear = 1'b1;
        @(negedge clk);
        ifa.i_clear = 1'b0;  ifb.i_clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (ifa.o_val !== 32'd0) begin errors++; $display("FAIL reset_val got %h want 0", ifa.o_val); end
        checks++;
        if (ifa.o_locked !== 2'b00) begin errors++; $display("FAIL reset_locked got %b want 00", ifa.o_locked); end
        checks++;
        if (ifa.o_lost !== 2'b00) begin errors++; $display("FAIL reset_lost got %b want 00", ifa.o_lost); end
        checks++;
        if (ifa.o_all_locked !== 1'b0) begin errors++; $display("FAIL reset_all got %b want 0", ifa.o_all_locked); end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 7; i++) send(2'b01, 16'd100, 16'd0);
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b00) begin errors++; $display("FAIL lock_early got %b want 00", ifa.o_locked); end
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b01) begin errors++; $display("FAIL lock_ch0 got %b want 01", ifa.o_locked); end
        checks++;
        if (ifa.o_val[15:0] !== 16'd100) begin errors++; $display("FAIL lock_val0 got %0d want 100", ifa.o_val[15:0]); end
        checks++;
        if (ifa.o_all_locked !== 1'b0) begin errors++; $display("FAIL lock_all_one got %b want 0", ifa.o_all_locked); end
        for (int i = 0; i < 7; i++) send(2'b10, 16'd0, 16'd20);
        idle(2);
        checks++;
        if (ifa.o_locked !== 2'b11 || ifa.o_all_locked !== 1'b1) begin
            errors++; $display("FAIL lock_both got %b/%b want 11/1", ifa.o_locked, ifa.o_all_locked);
        end
        checks++;
        if (ifa.o_val !== {16'd20, 16'd100}) begin errors++; $display("FAIL lock_vals got %h want 00140064", ifa.o_val); end
        pulse_clear();
    endtask

    task automatic test_tolerance();
        logic [15:0] tv [7];
        tv = '{16'd100, 16'd101, 16'd99, 16'd102, 16'd100, 16'd98, 16'd100};
        for (int i = 0; i < 7; i++) send(2'b01, tv[i], 16'd0);
        idle(2);
        checks++;
        if (ifb.o_locked[0] !== 1'b1 || ifb.o_val[15:0] !== 16'd100) begin
            errors++; $display("FAIL tol_lock got %b/%0d want 1/100", ifb.o_locked[0], ifb.o_val[15:0]);
        end
        checks++;
        if (ifa.o_locked[0] !== 1'b0) begin errors++; $display("FAIL tol0_nolock got %b want 0", ifa.o_locked[0]); end
        for (int k = 1; k <= 4; k++) begin
            send(2'b01, 16'd103, 16'd0);
            idle(2);
            checks++;
            if (ifb.o_locked[0] !== (k < 4) || ifb.o_lost[0] !== (k == 4)) begin
                errors++;
                $display("FAIL tol_decr%0d got locked %b lost %b want %b %b", k, ifb.o_locked[0], ifb.o_lost[0], k < 4, k == 4);
            end
        end
        pulse_clear();
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 7; i++) send(2'b01, 16'd100, 16'd0);
        idle(2);
        for (int k = 1; k <= 4; k++) begin
            send(2'b01, 16'd500, 16'd0);
            idle(2);
            checks++;
            if (ifa.o_locked[0] !== (k < 4) || ifa.o_lost[0] !== (k == 4)) begin
                errors++;
                $display("FAIL unlock_step%0d got locked %b lost %b want %b %b", k, ifa.o_locked[0], ifa.o_lost[0], k < 4, k == 4);
            end
        end
        checks++;
        if (ifa.o_val[15:0] !== UNLOCK_VAL) begin errors++; $display("FAIL unlock_val got %0d want %0d", ifa.o_val[15:0], UNLOCK_VAL); end
        idle(1);
        checks++;
        if (ifa.o_lost[0] !== 1'b0) begin errors++; $display("FAIL lost_width got %b want 0", ifa.o_lost[0]); end
        send(2'b01, 16'd500, 16'd0);
        idle(2);
        checks++;
        if (ifa.o_lost !== 2'b00 || ifa.o_locked !== 2'b00) begin
            errors++; $display("FAIL unlock_no_repulse got lost %b locked %b want 00 00", ifa.o_lost, ifa.o_locked);
        end
    endtask

    task automatic test_recapture();
        send(2'b01, 16'd500, 16'd0);
        send(2'b01, 16'd500, 16'd0);
        for (int i = 0; i < 6; i++) send(2'b01, 16'd500, 16'd0);
        idle(2);
        checks++;
        if (ifa.o_locked[0] !== 1'b0 || ifa.o_val[15:0] !== UNLOCK_VAL) begin
            errors++; $display("FAIL recap_early got %b/%0d want 0/%0d", ifa.o_locked[0], ifa.o_val[15:0], UNLOCK_VAL);
        end
        send(2'b01, 16'd500, 16'd0);
        idle(1);
        checks++;
        if (ifa.o_locked[0] !== 1'b0) begin errors++; $display("FAIL recap_latency got %b want 0", ifa.o_locked[0]); end
        idle(1);
        checks++;
        if (ifa.o_locked[0] !== 1'b1 || ifa.o_val[15:0] !== 16'd500) begin
            errors++; $display("FAIL recap_lock got %b/%0d want 1/500", ifa.o_locked[0], ifa.o_val[15:0]);
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) send(2'b11, 16'd10, 16'd20);
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b00 || ifa.o_all_locked !== 1'b0) begin
            errors++; $display("FAIL b2b_early got %b/%b want 00/0", ifa.o_locked, ifa.o_all_locked);
        end
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b11 || ifa.o_all_locked !== 1'b1) begin
            errors++; $display("FAIL b2b_lock got %b/%b want 11/1", ifa.o_locked, ifa.o_all_locked);
        end
        checks++;
        if (ifa.o_val !== {16'd20, 16'd10} || ifa.o_lost !== 2'b00) begin
            errors++; $display("FAIL b2b_vals got %h lost %b want 0014000a 00", ifa.o_val, ifa.o_lost);
        end
    endtask

    task automatic test_clear();
        ifa.i_clear = 1'b1;  ifb.i_clear = 1'b1;
        set_in(2'b11, 16'd77, 16'd88);
        @(negedge clk);
        ifa.i_clear = 1'b0;  ifb.i_clear = 1'b0;
        set_in(2'b00, 16'd0, 16'd0);
        checks++;
        if (ifa.o_locked !== 2'b00 || ifa.o_all_locked !== 1'b0 || ifa.o_val !== 32'd0) begin
            errors++; $display("FAIL clear_out got %b/%b/%h want 00/0/0", ifa.o_locked, ifa.o_all_locked, ifa.o_val);
        end
        checks++;
        if (ifa.o_lost !== 2'b00) begin errors++; $display("FAIL clear_lost got %b want 00", ifa.o_lost); end
        idle(2);
        checks++;
        if (ifa.o_lost !== 2'b00) begin errors++; $display("FAIL clear_lost_late got %b want 00", ifa.o_lost); end
        for (int i = 0; i < 6; i++) send(2'b01, 16'd77, 16'd0);
        idle(2);
        checks++;
        if (ifa.o_locked !== 2'b00) begin errors++; $display("FAIL clear_discard got %b want 00", ifa.o_locked); end
        send(2'b01, 16'd77, 16'd0);
        idle(2);
        checks++;
        if (ifa.o_locked !== 2'b01 || ifa.o_val[15:0] !== 16'd77) begin
            errors++; $display("FAIL clear_relock got %b/%0d want 01/77", ifa.o_locked, ifa.o_val[15:0]);
        end
    endtask

    task automatic test_async_reset();
        set_in(2'b11, 16'd5, 16'd6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.o_locked !== 2'b00 || ifa.o_val !== 32'd0 || ifa.o_lost !== 2'b00 || ifa.o_all_locked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%h/%b/%b want 00/0/00/0", ifa.o_locked, ifa.o_val, ifa.o_lost, ifa.o_all_locked);
        end
        set_in(2'b00, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send(2'b01, 16'd55, 16'd0);
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b00) begin errors++; $display("FAIL post_reset_early got %b want 00", ifa.o_locked); end
        idle(1);
        checks++;
        if (ifa.o_locked !== 2'b01 || ifa.o_val[15:0] !== 16'd55) begin
            errors++; $display("FAIL post_reset_lock got %b/%0d want 01/55", ifa.o_locked, ifa.o_val[15:0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.i_clear = 1'b0;  ifb.i_clear = 1'b0;
        set_in(2'b00, 16'd0, 16'd0);
        idle(2);
        test_reset();
        rst_n = 1'b1;
        test_lock();
        test_tolerance();
        test_unlock();
        test_recapture();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
